// File: rtl/pito_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pito_pkg
//  Description : Shared pito constants, interrupt event type and IRQ arbiter
//                FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package pito_pkg;

    localparam int          NUM_HARTS      = 8;
    localparam int          HART_CNT_WIDTH = $clog2(NUM_HARTS);
    localparam int          IRQ_MVU_INTR   = 16;
    localparam int          MIP_MVIP       = 16;
    localparam logic [31:0] MVU_INTR       = 32'h8000_0010;

    typedef struct packed {
        logic                      valid;
        logic [HART_CNT_WIDTH:0]   hart_id;
        logic [31:0]               data;
    } irq_evt_t;

    typedef enum logic {
        IRQ_ARB_IDLE,
        IRQ_ARB_OFFER
    } irq_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/pito_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pito_rr_arbiter
//  Description : Combinational round-robin picker: first requester at or
//                after ptr, scanning upward with wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module pito_rr_arbiter #(
    parameter int NUM_HARTS      = 8,
    parameter int HART_CNT_WIDTH = $clog2(NUM_HARTS)
) (
    input  logic [NUM_HARTS-1:0]      req,
    input  logic [HART_CNT_WIDTH-1:0] ptr,
    output logic [HART_CNT_WIDTH-1:0] gnt_idx,
    output logic                      gnt_any
);

    int                        w_idx;
    logic [HART_CNT_WIDTH-1:0] w_cand;

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        w_idx   = 0;
        w_cand  = '0;
        for (int i = NUM_HARTS - 1; i >= 0; i--) begin
            w_idx = int'(ptr) + i;
            if (w_idx >= NUM_HARTS) begin
                w_idx = w_idx - NUM_HARTS;
            end
            w_cand = HART_CNT_WIDTH'(w_idx);
            if (req[w_cand]) begin
                gnt_idx = w_cand;
                gnt_any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pito_irq_arb.sv
`default_nettype none
// ============================================================================
//  Module      : pito_irq_arb
//  Description : Per-hart MVU interrupt collector with round-robin offer of
//                one irq_evt_t at a time. Optional macro PITO_IRQ_STAMP_EN
//                replaces the event data with a captured cycle stamp.
//  Revision    : 1.0 - initial release
// ============================================================================
module pito_irq_arb
    import pito_pkg::*;
#(
    parameter int NUM_HARTS      = pito_pkg::NUM_HARTS,
    parameter int HART_CNT_WIDTH = $clog2(NUM_HARTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_HARTS-1:0] mvu_irq_i,
    input  logic [NUM_HARTS-1:0] mie_mvie_i,
    input  logic [NUM_HARTS-1:0] clr_i,
    output irq_evt_t             irq_o,
    input  logic                 irq_ready_i,
    output logic [NUM_HARTS-1:0] mip_mvip_o,
    output logic [NUM_HARTS-1:0] ovf_o
);

    irq_arb_state_t            r_state, w_state_nxt;
    irq_evt_t                  r_irq, w_irq_nxt;
    logic [NUM_HARTS-1:0]      r_pend, r_insvc, r_ovf;
    logic [HART_CNT_WIDTH-1:0] r_rr_ptr, r_offer_idx, w_offer_nxt;
    logic [NUM_HARTS-1:0]      w_eligible, w_hs_vec;
    logic [HART_CNT_WIDTH-1:0] w_gnt_idx;
    logic                      w_gnt_any, w_hs;
    logic [31:0]               w_evt_data;

    assign w_eligible = r_pend & mie_mvie_i & ~r_insvc;
    assign w_hs       = (r_state == IRQ_ARB_OFFER) & irq_ready_i;
    assign w_hs_vec   = w_hs ? ({{(NUM_HARTS-1){1'b0}}, 1'b1} << r_offer_idx) : '0;

    pito_rr_arbiter #(
        .NUM_HARTS      (NUM_HARTS),
        .HART_CNT_WIDTH (HART_CNT_WIDTH)
    ) u_rr (
        .req     (w_eligible),
        .ptr     (r_rr_ptr),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

`ifdef PITO_IRQ_STAMP_EN
    logic [30:0] r_cnt;
    logic [30:0] r_stamp [NUM_HARTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                r_stamp[h] <= '0;
            end
        end else begin
            r_cnt <= r_cnt + 31'd1;
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (mvu_irq_i[h]) begin
                    r_stamp[h] <= r_cnt;
                end
            end
        end
    end

    assign w_evt_data = {1'b1, r_stamp[w_gnt_idx]};
`else
    assign w_evt_data = MVU_INTR;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IRQ_ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The offer is only ever retracted by the handshake, never by mie or clr.
    always_comb begin
        w_state_nxt = r_state;
        w_irq_nxt   = r_irq;
        w_offer_nxt = r_offer_idx;
        case (r_state)
            IRQ_ARB_IDLE: begin
                if (w_gnt_any) begin
                    w_state_nxt                             = IRQ_ARB_OFFER;
                    w_irq_nxt.valid                         = 1'b1;
                    w_irq_nxt.hart_id                       = '0;
                    w_irq_nxt.hart_id[HART_CNT_WIDTH-1:0]   = w_gnt_idx;
                    w_irq_nxt.data                          = w_evt_data;
                    w_offer_nxt                             = w_gnt_idx;
                end
            end
            IRQ_ARB_OFFER: begin
                if (irq_ready_i) begin
                    w_state_nxt     = IRQ_ARB_IDLE;
                    w_irq_nxt.valid = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq       <= '0;
            r_offer_idx <= '0;
            r_rr_ptr    <= '0;
            r_pend      <= '0;
            r_insvc     <= '0;
            r_ovf       <= '0;
        end else begin
            r_irq       <= w_irq_nxt;
            r_offer_idx <= w_offer_nxt;
            r_pend      <= (r_pend & ~w_hs_vec) | mvu_irq_i;
            r_insvc     <= (r_insvc & ~clr_i) | w_hs_vec;
            r_ovf       <= (r_ovf & ~clr_i) | (mvu_irq_i & r_pend & ~w_hs_vec);
            if (w_hs) begin
                r_rr_ptr <= (r_offer_idx == HART_CNT_WIDTH'(NUM_HARTS - 1)) ? '0
                                                                            : r_offer_idx + 1'b1;
            end
        end
    end

    assign irq_o      = r_irq;
    assign mip_mvip_o = r_pend | r_insvc;
    assign ovf_o      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pito_irq_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pito_irq_arb
//  Description : Scenario bench for pito_irq_arb with an expected-event queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pito_irq_arb;
    import pito_pkg::*;

    localparam int NH = 8;

    typedef struct {
        logic [3:0]  hart;
        logic [31:0] data;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [NH-1:0] mvu_irq_i;
    logic [NH-1:0] mie_mvie_i;
    logic [NH-1:0] clr_i;
    irq_evt_t      irq_o;
    logic          irq_ready_i;
    logic [NH-1:0] mip_mvip_o;
    logic [NH-1:0] ovf_o;

    exp_t        sb[$];
    int          n_checks;
    int          n_errors;
    int          cyc;
    logic [30:0] tb_cnt;

    pito_irq_arb #(.NUM_HARTS(NH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mvu_irq_i   (mvu_irq_i),
        .mie_mvie_i  (mie_mvie_i),
        .clr_i       (clr_i),
        .irq_o       (irq_o),
        .irq_ready_i (irq_ready_i),
        .mip_mvip_o  (mip_mvip_o),
        .ovf_o       (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference free-running cycle count used for stamped event data.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cnt <= '0;
        else        tb_cnt <= tb_cnt + 31'd1;
    end

    function automatic logic [31:0] exp_data();
`ifdef PITO_IRQ_STAMP_EN
        return {1'b1, tb_cnt};
`else
        return 32'h8000_0010;
`endif
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [3:0] h);
        exp_t e;
        e.hart = h;
        e.data = exp_data();
        sb.push_back(e);
    endtask

    task automatic pulse(input logic [NH-1:0] m);
        mvu_irq_i = m;
        tick();
        mvu_irq_i = '0;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        mvu_irq_i   = '0;
        mie_mvie_i  = '1;
        clr_i       = '0;
        irq_ready_i = 1'b1;
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_offer(output int at);
        exp_t e;
        int   n;
        n = 0;
        while (irq_o.valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_checks++;
        at = cyc;
        if (irq_o.valid !== 1'b1) begin
            $display("FAIL offer_timeout: valid=%b required 1", irq_o.valid);
            n_errors++;
            at = -1;
        end else if (sb.size() == 0) begin
            $display("FAIL offer_unexpected: hart_id=%0d required no offer", irq_o.hart_id);
            n_errors++;
        end else begin
            e = sb.pop_front();
            if (irq_o.hart_id !== e.hart || irq_o.data !== e.data) begin
                $display("FAIL offer_content: hart_id=%0d data=%h required hart_id=%0d data=%h",
                         irq_o.hart_id, irq_o.data, e.hart, e.data);
                n_errors++;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (irq_o !== '0) begin
            $display("FAIL reset_irq: irq_o=%h required 0", irq_o); n_errors++;
        end
        n_checks++;
        if (mip_mvip_o !== '0) begin
            $display("FAIL reset_mip: mip=%b required 0", mip_mvip_o); n_errors++;
        end
        n_checks++;
        if (ovf_o !== '0) begin
            $display("FAIL reset_ovf: ovf=%b required 0", ovf_o); n_errors++;
        end
    endtask

    task automatic test_latency();
        int at;
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        push(4'd3);
        pulse(8'h08);
        n_checks++;
        if (mip_mvip_o[3] !== 1'b1 || irq_o.valid !== 1'b0) begin
            $display("FAIL lat_t1: mip3=%b valid=%b required 1 0", mip_mvip_o[3], irq_o.valid);
            n_errors++;
        end
        tick();
        n_checks++;
        if (irq_o.valid !== 1'b1) begin
            $display("FAIL lat_t2: valid=%b required 1", irq_o.valid); n_errors++;
        end
        wait_offer(at);
        tick();
        n_checks++;
        if (irq_o.valid !== 1'b0 || mip_mvip_o[3] !== 1'b1 || ovf_o !== '0) begin
            $display("FAIL lat_t3: valid=%b mip3=%b ovf=%b required 0 1 0",
                     irq_o.valid, mip_mvip_o[3], ovf_o);
            n_errors++;
        end
    endtask

    task automatic test_round_robin();
        int c0, c1, c2, c3, c4;
        do_reset();
        push(4'd0); push(4'd2); push(4'd7);
        pulse(8'h85);
        wait_offer(c0); tick();
        wait_offer(c1); tick();
        wait_offer(c2); tick();
        n_checks++;
        if (c1 - c0 != 2 || c2 - c1 != 2) begin
            $display("FAIL rr_spacing: gaps=%0d,%0d required 2,2", c1 - c0, c2 - c1);
            n_errors++;
        end
        clr_i = 8'h85;
        tick();
        clr_i = '0;
        push(4'd0); push(4'd7);
        pulse(8'h81);
        wait_offer(c3); tick();
        wait_offer(c4); tick();
    endtask

    task automatic test_wrap();
        int at;
        do_reset();
        push(4'd6);
        pulse(8'h40);
        wait_offer(at); tick();
        clr_i = 8'h40;
        tick();
        clr_i = '0;
        push(4'd0);
        pulse(8'h01);
        wait_offer(at); tick();
        clr_i = 8'h01;
        tick();
        clr_i = '0;
        push(4'd1); push(4'd0);
        pulse(8'h03);
        wait_offer(at); tick();
        wait_offer(at); tick();
    endtask

    task automatic test_backpressure();
        irq_evt_t snap;
        int       at;
        do_reset();
        irq_ready_i = 1'b0;
        push(4'd6);
        pulse(8'h40);
        wait_offer(at);
        snap = irq_o;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) mie_mvie_i[6] = 1'b0;
            clr_i = (i == 2) ? 8'h40 : 8'h00;
            tick();
            n_checks++;
            if (irq_o !== snap) begin
                $display("FAIL hold_stable: irq_o=%h required %h (cycle %0d)", irq_o, snap, i);
                n_errors++;
            end
        end
        clr_i       = '0;
        irq_ready_i = 1'b1;
        tick();
        n_checks++;
        if (irq_o.valid !== 1'b0 || mip_mvip_o[6] !== 1'b1) begin
            $display("FAIL hold_release: valid=%b mip6=%b required 0 1", irq_o.valid, mip_mvip_o[6]);
            n_errors++;
        end
        mie_mvie_i = '1;
    endtask

    task automatic test_masked_ovf();
        int at;
        do_reset();
        mie_mvie_i[5] = 1'b0;
        pulse(8'h20);
        tick();
        push(4'd5);
        pulse(8'h20);
        tick(); tick(); tick();
        n_checks++;
        if (irq_o.valid !== 1'b0 || ovf_o[5] !== 1'b1 || mip_mvip_o[5] !== 1'b1) begin
            $display("FAIL masked_hold: valid=%b ovf5=%b mip5=%b required 0 1 1",
                     irq_o.valid, ovf_o[5], mip_mvip_o[5]);
            n_errors++;
        end
        mie_mvie_i[5] = 1'b1;
        wait_offer(at);
        tick();
        clr_i = 8'h20;
        tick();
        clr_i = '0;
        n_checks++;
        if (ovf_o[5] !== 1'b0 || mip_mvip_o[5] !== 1'b0) begin
            $display("FAIL masked_clear: ovf5=%b mip5=%b required 0 0", ovf_o[5], mip_mvip_o[5]);
            n_errors++;
        end
    endtask

    task automatic test_async_reset();
        int   at;
        logic saw;
        do_reset();
        mie_mvie_i[1] = 1'b0;
        pulse(8'h02);
        tick();
        pulse(8'h02);
        irq_ready_i = 1'b0;
        push(4'd2);
        pulse(8'h04);
        wait_offer(at);
        n_checks++;
        if (ovf_o[1] !== 1'b1) begin
            $display("FAIL pre_reset_ovf: ovf1=%b required 1", ovf_o[1]); n_errors++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (irq_o.valid !== 1'b0 || mip_mvip_o !== '0 || ovf_o !== '0) begin
            $display("FAIL async_reset: valid=%b mip=%b ovf=%b required 0 0 0",
                     irq_o.valid, mip_mvip_o, ovf_o);
            n_errors++;
        end
        tick(); tick();
        rst_n       = 1'b1;
        mie_mvie_i  = '1;
        irq_ready_i = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (irq_o.valid !== 1'b0) saw = 1'b1;
        end
        n_checks++;
        if (saw !== 1'b0) begin
            $display("FAIL stale_offer: valid seen=%b required 0", saw); n_errors++;
        end
    endtask

`ifdef PITO_IRQ_STAMP_EN
    task automatic test_stamp();
        int at;
        int n;
        do_reset();
        n = 0;
        while (tb_cnt != 31'h100 && n < 400) begin
            tick();
            n++;
        end
        push(4'd1);
        pulse(8'h02);
        n_checks++;
        if (sb.size() != 1 || sb[0].data !== 32'h8000_0100) begin
            $display("FAIL stamp_setup: queued=%0d required data 80000100", sb.size());
            n_errors++;
        end
        wait_offer(at);
        tick();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_latency();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_masked_ovf();
        test_async_reset();
`ifdef PITO_IRQ_STAMP_EN
        test_stamp();
`endif
        n_checks++;
        if (sb.size() != 0) begin
            $display("FAIL sb_drain: %0d expected offers never seen, required 0", sb.size());
            n_errors++;
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pito_irq_arb.md
Name: pito_irq_arb

Overview:
- Per-hart MVU interrupt collector and arbiter, directly upstream of each hart's CSR/trap logic.
- Latches MVU completion pulses per hart and gates them with the per-hart MVIE enable.
- Picks one eligible hart round-robin and presents it as one irq_evt_t on a valid/ready channel.
- Tracks pending and in-service state until software clears it (MRET or a CSR write to MIP).

Parameters:
- NUM_HARTS, default pito_pkg::NUM_HARTS (8): number of harts served; must be 2 or more.
- HART_CNT_WIDTH, default $clog2(NUM_HARTS): width of the hart index.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- mvu_irq_i  in  NUM_HARTS  one-cycle MVU completion pulse, one bit per hart.
- mie_mvie_i  in  NUM_HARTS  per-hart MIE bit IRQ_MVU_INTR (16), from the CSR unit.
- clr_i  in  NUM_HARTS  per-hart end-of-service pulse (MRET, or a CSR_CLEAR of MIP_MVIP).
- irq_o  out  $bits(irq_evt_t)  event; irq_o.valid is the valid signal.
- irq_ready_i  in  1  consumer accepts irq_o in a cycle where valid and ready are both high.
- mip_mvip_o  out  NUM_HARTS  per-hart pending-or-in-service bit, mirrored into MIP bit 16.
- ovf_o  out  NUM_HARTS  sticky overflow: a pulse arrived while that hart was already pending.

Behaviour:
- Per-hart state is pend[h] and insvc[h]; mip_mvip_o[h] = pend[h] | insvc[h].
- Reset (async assert, sync deassert): pend, insvc, ovf_o = 0; rr_ptr = 0; FSM = IDLE; irq_o = 0 (valid, hart_id and data all 0).
- Set rule: mvu_irq_i[h] sets pend[h] on the next edge. If pend[h] is already 1, it also sets ovf_o[h].
- Eligible[h] = pend[h] & mie_mvie_i[h] & ~insvc[h].
- FSM IDLE:
  - If any hart is eligible, grant the first eligible hart at or after rr_ptr, scanning upward with wrap-around.
  - Register irq_o.valid=1, hart_id=h (zero-extended to HART_CNT_WIDTH+1) and data=MVU_INTR (0x8000_0010). Go to OFFER.
- FSM OFFER:
  - irq_o is held bit-stable until irq_ready_i.
  - A drop of mie_mvie_i[h] or a clr_i[h] during OFFER does not retract the offer.
  - On handshake: pend[h] <= 0, insvc[h] <= 1, rr_ptr <= (h+1) mod NUM_HARTS, irq_o.valid <= 0, go to IDLE.
- Latency: pulse at cycle t, pend at t+1, irq_o.valid at t+2, provided the FSM is idle and mie is set.
- Minimum spacing between two offers is 2 cycles: handshake cycle, then IDLE grant.
- clr_i[h]: insvc[h] <= 0 and ovf_o[h] <= 0. pend[h] is unaffected.
- Simultaneous events on the same hart, same cycle:
  - Pulse + handshake: pend stays 1, insvc becomes 1, ovf_o is not set.
  - Pulse + clr_i: insvc cleared, pend set.
  - clr_i + handshake: insvc ends at 1 (handshake wins).
- A pending hart with mie=0 stays pending. It becomes eligible when mie rises; no event is lost.
- NUM_HARTS wrap: with rr_ptr=NUM_HARTS-1 and only hart 0 eligible, hart 0 is granted and rr_ptr becomes 1.

Optional Feature:
- Macro: PITO_IRQ_STAMP_EN.
- Defined:
  - A 31-bit free-running cycle counter (reset 0, wraps) is captured into stamp[h] on every set of pend[h].
  - irq_o.data = {1'b1, stamp[h]}.
- Undefined: no counter or stamp registers; irq_o.data = MVU_INTR.

Decomposition:
- pito_pkg already holds irq_evt_t, IRQ_MVU_INTR, MIP_MVIP and MVU_INTR.
- Add to pito_pkg: typedef enum logic {IRQ_ARB_IDLE, IRQ_ARB_OFFER} irq_arb_state_t.
- One sub-module: pito_rr_arbiter.
  - Combinational: inputs req[NUM_HARTS] and ptr; outputs gnt_idx and gnt_any.
  - Parameterised on NUM_HARTS; reusable by the MVU command path.

Test Plan:
1. Reset release, all mie=1, pulse hart 3 at cycle 10 -> irq_o.valid at cycle 12 with hart_id=3, data=0x8000_0010. Ready held high: mip_mvip_o[3]=1 through handshake, insvc[3]=1 after it, irq_o.valid low at cycle 13.
2. Pulse harts 0, 2 and 7 in the same cycle, ready always 1 -> grants in order 0, 2, 7, each 2 cycles apart. Then re-pulse 0 and 7 with insvc cleared -> hart 7 is not served before hart 0 after the wrap (rr_ptr=0 after serving 7).
3. Ready held low for 5 cycles while mie_mvie_i[h] drops and clr_i[h] pulses -> irq_o stays bit-identical throughout, handshake completes when ready rises, insvc[h]=1.
4. mie_mvie_i[5]=0, pulse hart 5 twice -> no offer, ovf_o[5]=1, mip_mvip_o[5]=1. Then raise mie -> offer for hart 5. Then clr_i[5] -> ovf_o[5]=0, mip_mvip_o[5]=0.
5. Assert rst_n low mid-OFFER -> irq_o.valid falls asynchronously, all mip/ovf bits 0. After release, no stale offer appears.
6. With PITO_IRQ_STAMP_EN, pulse hart 1 at counter value 0x100 -> irq_o.data=0x8000_0100.
